multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control sequencer for the multi-cycle RV32I core (lw, sw, R-type, I-ALU, beq, jal, lui).
//  Decodes op/funct fields from the instruction register and steps the shared datapath
//  (ALU, immediate extender, memory port, register file) through FETCH..WRITEBACK.
//  Drives immsrc for the extender; stalls on a memory ready handshake.
// PARAMETERS
//  MEM_WAIT_MAX  16  cycles to wait for mem_ready before asserting trap (timeout)
// PORTS
//  clk          in   1  core clock, all state updates on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  op           in   7  instr[6:0] from instruction register
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  zero         in   1  ALU zero flag (valid in cycle of BEQ state)
//  mem_ready    in   1  memory completes current read/write this cycle
//  pc_write     out  1  load PC
//  adr_src      out  1  0=PC, 1=ALUOut drives memory address
//  mem_req      out  1  memory access requested (held until mem_ready)
//  mem_write    out  1  access is a write (qualifies mem_req)
//  ir_write     out  1  load instruction register and OldPC
//  reg_write    out  1  register-file write enable
//  result_src   out  2  00=ALUOut 01=Data 10=ALUResult
//  alu_src_a    out  2  00=PC 01=OldPC 10=rs1
//  alu_src_b    out  2  00=rs2 01=imm 10=const 4
//  alu_control  out  3  000 add 001 sub 010 and 011 or 101 slt
//  immsrc       out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
//  trap         out  1  sticky: illegal opcode or memory timeout
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=FETCH, wait counter=0, trap=0; all enables 0.
//  - Outputs are Moore-decoded from state except immsrc, alu_control (decode of op/funct),
//    and pc_write in BEQ (= zero).
//  - States/transitions:
//    FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu add. On mem_ready: ir_write=1,
//           pc_write=1, result_src=10 -> DECODE; else stay.
//    DECODE: alu_src_a=01, alu_src_b=01 (branch target). op 0000011/0100011 -> MEMADR;
//           0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; 0110111 -> LUI;
//           other -> TRAP.
//    MEMADR: rs1+imm; lw -> MEMREAD, sw -> MEMWRITE.
//    MEMREAD: mem_req=1, adr_src=1; mem_ready -> MEMWB. MEMWB: result_src=01, reg_write -> FETCH.
//    MEMWRITE: mem_req=1, mem_write=1, adr_src=1; mem_ready -> FETCH.
//    EXECR/EXECI: rs1 op rs2/imm -> ALUWB. ALUWB: result_src=00, reg_write -> FETCH.
//    BEQ: sub rs1,rs2, result_src=00, pc_write=zero -> FETCH.
//    JAL: OldPC+4 to ALUOut, pc_write with target from DECODE -> ALUWB.
//    LUI: alu_src_b=01, immsrc=U, pass-through add with zero A -> ALUWB.
//    TRAP: all enables 0, trap=1; leaves only via reset.
//  - alu_control: add for lw/sw/jal/lui/fetch; sub for beq; for R/I: funct3 000 -> add,
//    except R-type with funct7b5=1 -> sub; 010 slt, 110 or, 111 and; other funct3 -> TRAP.
//  - Wait counter: increments each cycle mem_req=1 && !mem_ready, clears on mem_ready or
//    state change; reaching MEM_WAIT_MAX -> TRAP (counter saturates, no wrap).
//  - mem_ready outside a memory state is ignored. mem_req/adr_src/mem_write stable while waiting.
//  - Latencies with mem_ready=1 every access: lw 5, sw 4, R/I 4, beq 3, jal 4, lui 4 cycles.
//  - Reset asserted mid-access: mem_req drops immediately (async); restart at FETCH.
// STRUCTURE
//  - Package core_ctrl_pkg: state_t enum, opcode localparams, immsrc_t/alu_op_t/result_src_t
//    encodings (shared with the immediate extender and ALU).
//  - One sub-module: ctrl_alu_decoder (op, funct3, funct7b5 -> alu_control, illegal flag).
//  - FSM state register + wait counter in this module; output decode in one always_comb.
// TESTING
//  - Reset mid-FETCH with mem_req=1 -> mem_req=0 same cycle; FETCH, trap=0 after release.
//  - lw x1,4(x2) (op 0000011), mem_ready=1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; immsrc=000, reg_write=1 in cycle 5.
//  - sw, mem_ready low 3 cycles in MEMWRITE -> mem_req/mem_write held 4 cycles, then FETCH.
//  - beq with zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; immsrc=010 in DECODE.
//  - sub (funct7b5=1, funct3=000) -> alu_control=001; addi same fields -> 000.
//  - op=1111111 -> TRAP, trap=1 sticky; mem_ready stuck 0 for 16 cycles in FETCH -> trap=1.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// and the select/op codes consumed by the immediate extender, ALU and result mux.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } immsrc_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10
  } result_src_t;

  // SRCA_ZERO gives LUI a zero A operand so the ALU passes the U-immediate through.
  typedef enum logic [1:0] {
    SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
  } src_b_t;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE: return IMM_S;
      OP_BEQ:   return IMM_B;
      OP_JAL:   return IMM_J;
      OP_LUI:   return IMM_U;
      default:  return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_alu_decoder.sv
// ALU operation decode from op/funct fields; flags unsupported opcodes and funct3 values.
module ctrl_alu_decoder
  import core_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (op_i)
      OP_LOAD, OP_STORE, OP_JAL, OP_LUI: alu_control_o = ALU_ADD;
      OP_BEQ: alu_control_o = ALU_SUB;
      OP_R, OP_I: begin
        case (funct3_i)
          // funct7b5 only selects sub for register-register ops; addi ignores it
          3'b000:  alu_control_o = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control sequencer for the multi-cycle RV32I core: steps the shared datapath
// FETCH..WRITEBACK, stalls on mem_ready and traps on illegal ops or memory timeout.
module multicycle_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] immsrc,
  output logic       trap
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [2:0]      dec_alu;
  logic            dec_illegal;
  logic            in_mem, timeout;

  ctrl_alu_decoder u_alu_dec (
    .op_i          (op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_control_o (dec_alu),
    .illegal_o     (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign in_mem  = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  assign timeout = in_mem && !mem_ready && (wait_q >= CW'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) state_d = S_TRAP;
        else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_I:              state_d = S_EXECI;
            OP_BEQ:            state_d = S_BEQ;
            OP_JAL:            state_d = S_JAL;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_TRAP;
          endcase
        end
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL,
      S_LUI:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_TRAP;
  end

  always_comb begin
    wait_d = wait_q;
    if (mem_ready || state_d != state_q) wait_d = '0;
    else if (in_mem && wait_q != CW'(MEM_WAIT_MAX)) wait_d = wait_q + CW'(1);
  end

  assign immsrc = imm_sel(op);

  // Enables are masked by rst_n so an in-flight access drops the instant reset asserts.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    trap        = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = (state_q == S_FETCH || state_q == S_DECODE) ? ALU_ADD : dec_alu;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURES;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: alu_src_a = SRCA_RS1;
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = SRCA_RS1;
          pc_write  = zero;
        end
        // ALUOut still holds the branch/jump target computed in DECODE
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_LUI: begin
          alu_src_a = SRCA_ZERO;
          alu_src_b = SRCB_IMM;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected control vectors
// are queued as stimulus is applied and compared against the DUT outputs.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       pcw, adr, req, wr, irw, rw;
    logic [1:0] rs, a, b;
    logic [2:0] alu, imm;
    logic       trap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, immsrc;
  exp_t       act;
  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0;

  multicycle_ctrl_fsm #(.MEM_WAIT_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .immsrc(immsrc), .trap(trap)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_control, immsrc, trap};

  function automatic exp_t ex(int pcw, int adr, int req, int wr, int irw, int rw,
                              int rs, int a, int b, int alu, int imm, int tr);
    exp_t e;
    e.pcw = 1'(pcw); e.adr = 1'(adr); e.req = 1'(req); e.wr = 1'(wr);
    e.irw = 1'(irw); e.rw = 1'(rw); e.rs = 2'(rs); e.a = 2'(a); e.b = 2'(b);
    e.alu = 3'(alu); e.imm = 3'(imm); e.trap = 1'(tr);
    return e;
  endfunction

  function automatic exp_t f_rdy(int imm);  return ex(1,0,1,0,1,0, 2,0,2, 0,imm,0); endfunction
  function automatic exp_t f_wait(int imm); return ex(0,0,1,0,0,0, 2,0,2, 0,imm,0); endfunction
  function automatic exp_t dec(int imm);    return ex(0,0,0,0,0,0, 0,1,1, 0,imm,0); endfunction

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic r);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = r;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #3;
    sb.push_back(ex(0,0,0,0,0,0, 0,0,0, 0,0,0));
    e = sb.pop_front(); n_chk++;
    if (act !== e) begin n_fail++; $display("FAIL reset_hold got %h want %h", act, e); end
    @(posedge clk); #1 rst_n = 1'b1;
    sb.push_back(f_wait(0));
    @(negedge clk);
    e = sb.pop_front(); n_chk++;
    if (act !== e) begin n_fail++; $display("FAIL reset_fetch got %h want %h", act, e); end
    @(posedge clk); #2 rst_n = 1'b0;
    sb.push_back(ex(0,0,0,0,0,0, 0,0,0, 0,0,0));
    #1;
    e = sb.pop_front(); n_chk++;
    if (act !== e) begin n_fail++; $display("FAIL reset_async_drop got %h want %h", act, e); end
    @(posedge clk); #1 rst_n = 1'b1;
    sb.push_back(f_wait(0));
    @(negedge clk);
    e = sb.pop_front(); n_chk++;
    if (act !== e) begin n_fail++; $display("FAIL reset_restart got %h want %h", act, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    exp_t q[$];
    exp_t e;
    q = '{f_rdy(0), dec(0), ex(0,0,0,0,0,0, 0,2,1, 0,0,0),
          ex(0,1,1,0,0,0, 0,0,0, 0,0,0), ex(0,0,0,0,0,1, 1,0,0, 0,0,0)};
    drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    foreach (q[i]) begin
      sb.push_back(q[i]);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL lw c%0d got %h want %h", i, act, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    exp_t q[$];
    exp_t e;
    logic [6:0] rdy;
    rdy = 7'b1000111;
    q = '{f_rdy(1), dec(1), ex(0,0,0,0,0,0, 0,2,1, 0,1,0)};
    for (int k = 0; k < 4; k++) q.push_back(ex(0,1,1,1,0,0, 0,0,0, 0,1,0));
    foreach (q[i]) begin
      drive(7'b0100011, 3'b010, 1'b0, 1'b0, rdy[i]);
      sb.push_back(q[i]);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL sw c%0d got %h want %h", i, act, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    exp_t q[$];
    exp_t e;
    logic [6:0] ops [3];
    logic [2:0] f3s [3];
    int exec_b [3], alu [3];
    ops = '{7'b0110011, 7'b0010011, 7'b0110011};
    f3s = '{3'b000, 3'b000, 3'b110};
    exec_b = '{0, 1, 0};
    alu = '{1, 0, 3};
    for (int t = 0; t < 3; t++) begin
      q = '{f_rdy(0), dec(0), ex(0,0,0,0,0,0, 0,2,exec_b[t], alu[t],0,0),
            ex(0,0,0,0,0,1, 0,0,0, alu[t],0,0)};
      drive(ops[t], f3s[t], 1'b1, 1'b0, 1'b1);
      foreach (q[i]) begin
        sb.push_back(q[i]);
        @(negedge clk);
        e = sb.pop_front(); n_chk++;
        if (act !== e) begin n_fail++; $display("FAIL alu%0d c%0d got %h want %h", t, i, act, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_beq();
    exp_t q[$];
    exp_t e;
    for (int z = 1; z >= 0; z--) begin
      q = '{f_rdy(2), dec(2), ex(z,0,0,0,0,0, 0,2,0, 1,2,0)};
      drive(7'b1100011, 3'b000, 1'b0, 1'(z), 1'b1);
      foreach (q[i]) begin
        sb.push_back(q[i]);
        @(negedge clk);
        e = sb.pop_front(); n_chk++;
        if (act !== e) begin n_fail++; $display("FAIL beq_z%0d c%0d got %h want %h", z, i, act, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jal_lui();
    exp_t q[$];
    exp_t e;
    q = '{f_rdy(3), dec(3), ex(1,0,0,0,0,0, 0,1,2, 0,3,0), ex(0,0,0,0,0,1, 0,0,0, 0,3,0)};
    drive(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
    foreach (q[i]) begin
      sb.push_back(q[i]);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL jal c%0d got %h want %h", i, act, e); end
      @(posedge clk); #1;
    end
    q = '{f_rdy(4), dec(4), ex(0,0,0,0,0,0, 0,3,1, 0,4,0), ex(0,0,0,0,0,1, 0,0,0, 0,4,0)};
    drive(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b1);
    foreach (q[i]) begin
      sb.push_back(q[i]);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL lui c%0d got %h want %h", i, act, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    exp_t q[$];
    exp_t e;
    q = '{f_rdy(0), dec(0)};
    for (int k = 0; k < 3; k++) q.push_back(ex(0,0,0,0,0,0, 0,0,0, 0,0,1));
    drive(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
    foreach (q[i]) begin
      mem_ready = 1'(i % 2 == 0);
      sb.push_back(q[i]);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL illegal_op c%0d got %h want %h", i, act, e); end
      @(posedge clk); #1;
    end
    apply_reset();
    q = '{f_rdy(0), dec(0), ex(0,0,0,0,0,0, 0,0,0, 0,0,1)};
    drive(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b1);
    foreach (q[i]) begin
      sb.push_back(q[i]);
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL illegal_f3 c%0d got %h want %h", i, act, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    apply_reset();
    drive(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      sb.push_back(f_wait(0));
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL timeout_wait c%0d got %h want %h", i, act, e); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex(0,0,0,0,0,0, 0,0,0, 0,0,1));
      @(negedge clk);
      e = sb.pop_front(); n_chk++;
      if (act !== e) begin n_fail++; $display("FAIL timeout_trap c%0d got %h want %h", i, act, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu_ops();
    test_beq();
    test_jal_lui();
    test_illegal();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
